// File: rtl/dual_port_ram_pipe_if.sv
// Request/response bundle for dual_port_ram_pipe: one write port, one read port and status strobes.
interface dual_port_ram_pipe_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;

   logic                  EN_WR;
   logic [ADDR_WIDTH-1:0] ADDR_WR;
   logic [NUM_LANES-1:0]  BE_WR;
   logic [DATA_WIDTH-1:0] D_IN;
   logic                  EN_RD;
   logic [ADDR_WIDTH-1:0] ADDR_RD;
   logic [DATA_WIDTH-1:0] D_OUT;
   logic                  VALID_RD;
   logic                  BUSY;
   logic                  ERR_ADDR;

   modport master (
      output EN_WR, ADDR_WR, BE_WR, D_IN, EN_RD, ADDR_RD,
      input  D_OUT, VALID_RD, BUSY, ERR_ADDR
   );

   modport slave (
      input  EN_WR, ADDR_WR, BE_WR, D_IN, EN_RD, ADDR_RD,
      output D_OUT, VALID_RD, BUSY, ERR_ADDR
   );
endinterface

// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM with lane write enables, collision mode, 1/2-stage read pipe,
// address range checking and a post-reset clear sweep.
module dual_port_ram_pipe #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DEPTH      = 10,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned RW_MODE    = 0
) (
   input logic                 CLK,
   input logic                 RST,
   dual_port_ram_pipe_if.slave bus
);
   localparam int unsigned           NUM_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {StClear, StReady} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_in_range, rd_in_range, wr_fire, rd_fire, err_d;
   logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;
   logic [DATA_WIDTH-1:0] d1_q;
   logic                  v1_q, err_q;

   always_comb begin
      wr_in_range = {1'b0, bus.ADDR_WR} < DEPTH_W;
      rd_in_range = {1'b0, bus.ADDR_RD} < DEPTH_W;
      wr_fire     = !busy_q && bus.EN_WR && wr_in_range;
      rd_fire     = !busy_q && bus.EN_RD;
      err_d       = !busy_q && ((bus.EN_WR && !wr_in_range) || (bus.EN_RD && !rd_in_range));
      wr_old      = wr_in_range ? mem[bus.ADDR_WR] : '0;
      wr_merged   = wr_old;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         if (bus.BE_WR[k]) begin
            wr_merged[k*LANE_WIDTH +: LANE_WIDTH] = bus.D_IN[k*LANE_WIDTH +: LANE_WIDTH];
         end
      end
      // Out-of-range reads still complete, carrying zero.
      if (!rd_in_range) begin
         rd_word = '0;
      end else if (RW_MODE == 1 && wr_fire && bus.ADDR_WR == bus.ADDR_RD) begin
         rd_word = wr_merged;
      end else begin
         rd_word = mem[bus.ADDR_RD];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else if (state_q == StClear) begin
         clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
         if (clr_cnt_q == LAST) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
         end
      end
   end

   // Storage carries no reset; the sweep zeroes it after RST is released.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state_q == StClear) begin
            mem[clr_cnt_q] <= '0;
         end else if (wr_fire) begin
            mem[bus.ADDR_WR] <= wr_merged;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         d1_q  <= '0;
         v1_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         v1_q  <= rd_fire;
         err_q <= err_d;
         if (rd_fire) begin
            d1_q <= rd_word;
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] d2_q;
         logic                  v2_q;

         always_ff @(posedge CLK) begin
            if (RST) begin
               d2_q <= '0;
               v2_q <= 1'b0;
            end else begin
               v2_q <= v1_q;
               if (v1_q) begin
                  d2_q <= d1_q;
               end
            end
         end

         assign bus.D_OUT    = d2_q;
         assign bus.VALID_RD = v2_q;
      end else begin : g_lat1
         assign bus.D_OUT    = d1_q;
         assign bus.VALID_RD = v1_q;
      end
   endgenerate

   assign bus.BUSY     = busy_q;
   assign bus.ERR_ADDR = err_q;
endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Directed bench: two instances (latency 1/read-first and latency 2/write-first) share stimulus.
module tb_dual_port_ram_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_wr = 1'b0;
   logic [3:0]  addr_wr = '0;
   logic [1:0]  be_wr = '0;
   logic [15:0] d_in = '0;
   logic        en_rd = 1'b0;
   logic [3:0]  addr_rd = '0;

   int checks = 0;
   int failures = 0;

   logic [3:0]  ra [16];
   logic [15:0] rexp [16];
   logic [15:0] mdl [10];

   always #5 clk = ~clk;

   dual_port_ram_pipe_if #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4)) ia ();
   dual_port_ram_pipe_if #(.DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4)) ib ();

   assign ia.EN_WR = en_wr;  assign ib.EN_WR = en_wr;
   assign ia.ADDR_WR = addr_wr;  assign ib.ADDR_WR = addr_wr;
   assign ia.BE_WR = be_wr;  assign ib.BE_WR = be_wr;
   assign ia.D_IN = d_in;  assign ib.D_IN = d_in;
   assign ia.EN_RD = en_rd;  assign ib.EN_RD = en_rd;
   assign ia.ADDR_RD = addr_rd;  assign ib.ADDR_RD = addr_rd;

   dual_port_ram_pipe #(
      .DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(10), .RD_LATENCY(1), .RW_MODE(0)
   ) dut_a (
      .CLK(clk),
      .RST(rst),
      .bus(ia)
   );

   dual_port_ram_pipe #(
      .DATA_WIDTH(16), .LANE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(10), .RD_LATENCY(2), .RW_MODE(1)
   ) dut_b (
      .CLK(clk),
      .RST(rst),
      .bus(ib)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      en_wr = 1'b1; addr_wr = a; d_in = d; be_wr = be;
      step();
      en_wr = 1'b0;
   endtask

   // Called at the sample point right after the last reset edge.
   task automatic busy_measure(input string tag, input logic poke);
      int ca = 0;
      int cb = 0;
      logic stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (poke && i == 0) begin
            en_wr = 1'b1; addr_wr = 4'd3; d_in = 16'hFFFF; be_wr = 2'b11;
            en_rd = 1'b1; addr_rd = 4'd15;
         end
         if (i == 5) begin
            en_wr = 1'b0; en_rd = 1'b0;
         end
         ca += int'(ia.BUSY);
         cb += int'(ib.BUSY);
         stray |= ia.VALID_RD | ib.VALID_RD | ia.ERR_ADDR | ib.ERR_ADDR;
         step();
      end
      chk({tag, "_busy_a"}, ca, 10);
      chk({tag, "_busy_b"}, cb, 10);
      chk({tag, "_no_strobe"}, stray, 1'b0);
      chk({tag, "_ready"}, {ia.BUSY, ib.BUSY}, 2'b00);
   endtask

   // A sees read k after one edge, B after two.
   task automatic run_reads(input string tag, input int n);
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            en_rd = 1'b1; addr_rd = ra[i];
         end else begin
            en_rd = 1'b0;
         end
         step();
         chk({tag, "_va"}, ia.VALID_RD, i < n);
         if (i < n) chk({tag, "_da"}, ia.D_OUT, rexp[i]);
         chk({tag, "_vb"}, ib.VALID_RD, i >= 1 && i <= n);
         if (i >= 1 && i <= n) chk({tag, "_db"}, ib.D_OUT, rexp[i-1]);
      end
   endtask

   task automatic readback_all(input string tag);
      for (int i = 0; i < 10; i++) begin
         ra[i] = 4'(i);
         rexp[i] = mdl[i];
      end
      run_reads(tag, 10);
   endtask

   initial begin
      for (int i = 0; i < 10; i++) mdl[i] = 16'h0000;

      step();
      step();
      chk("rst_busy", {ia.BUSY, ib.BUSY}, 2'b11);
      chk("rst_valid", {ia.VALID_RD, ib.VALID_RD}, 2'b00);
      chk("rst_err", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b00);
      chk("rst_dout_a", ia.D_OUT, 16'h0000);
      chk("rst_dout_b", ib.D_OUT, 16'h0000);
      rst = 1'b0;
      busy_measure("clr1", 1'b1);
      readback_all("clr_read");

      for (int i = 0; i < 10; i++) begin
         wr(4'(i), 16'h00A0 + 16'(i), 2'b11);
         mdl[i] = 16'h00A0 + 16'(i);
      end
      for (int i = 0; i < 10; i++) begin
         ra[i] = 4'(9 - i);
         rexp[i] = 16'h00A9 - 16'(i);
      end
      run_reads("sweep", 10);

      wr(4'd5, 16'h1234, 2'b11);
      wr(4'd5, 16'hABCD, 2'b01);
      wr(4'd5, 16'hFFFF, 2'b00);
      chk("be0_no_err", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b00);
      mdl[5] = 16'h12CD;
      ra[0] = 4'd5; rexp[0] = 16'h12CD;
      run_reads("lanes", 1);

      wr(4'd2, 16'h0011, 2'b11);
      en_wr = 1'b1; addr_wr = 4'd2; d_in = 16'h0022; be_wr = 2'b11;
      en_rd = 1'b1; addr_rd = 4'd2;
      step();
      en_wr = 1'b0; en_rd = 1'b0;
      chk("coll_a", ia.D_OUT, 16'h0011);
      step();
      chk("coll_b", ib.D_OUT, 16'h0022);
      ra[0] = 4'd2; rexp[0] = 16'h0022;
      run_reads("coll_after", 1);

      en_wr = 1'b1; addr_wr = 4'd2; d_in = 16'hAB99; be_wr = 2'b01;
      en_rd = 1'b1; addr_rd = 4'd2;
      step();
      en_wr = 1'b0; en_rd = 1'b0;
      chk("merge_a", ia.D_OUT, 16'h0022);
      step();
      chk("merge_b", ib.D_OUT, 16'h0099);
      mdl[2] = 16'h0099;

      wr(4'd12, 16'hFFFF, 2'b11);
      chk("oob_wr_err", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b11);
      step();
      chk("oob_wr_err_clr", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b00);

      en_rd = 1'b1; addr_rd = 4'd15;
      step();
      en_rd = 1'b0;
      chk("oob_rd_va", ia.VALID_RD, 1'b1);
      chk("oob_rd_da", ia.D_OUT, 16'h0000);
      chk("oob_rd_err", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b11);
      chk("oob_rd_vb_early", ib.VALID_RD, 1'b0);
      step();
      chk("oob_rd_vb", ib.VALID_RD, 1'b1);
      chk("oob_rd_db", ib.D_OUT, 16'h0000);
      chk("oob_rd_err_clr", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b00);

      en_wr = 1'b1; addr_wr = 4'd12; d_in = 16'h5555; be_wr = 2'b11;
      en_rd = 1'b1; addr_rd = 4'd15;
      step();
      en_wr = 1'b0; en_rd = 1'b0;
      chk("oob_both_err", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b11);
      step();
      chk("oob_both_once", {ia.ERR_ADDR, ib.ERR_ADDR}, 2'b00);
      readback_all("oob_mem");

      en_rd = 1'b1; addr_rd = 4'd1;
      step();
      en_rd = 1'b0;
      rst = 1'b1;
      step();
      chk("rst_mid_valid", {ia.VALID_RD, ib.VALID_RD}, 2'b00);
      chk("rst_mid_dout_b", ib.D_OUT, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid_sweep_busy", {ia.BUSY, ib.BUSY}, 2'b11);
      rst = 1'b1;
      step();
      rst = 1'b0;
      busy_measure("clr2", 1'b0);
      for (int i = 0; i < 10; i++) mdl[i] = 16'h0000;
      readback_all("clr2_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dual_port_ram_pipe.md
Name: dual_port_ram_pipe

Overview:
Parametrised simple dual-port RAM (one write port, one read port, one clock) that supersedes the fixed-size DUAL_PORT_RAM. Adds per-lane write enables, selectable read-during-write collision mode, 1- or 2-stage read pipeline with a valid strobe, out-of-range address detection, and a post-reset memory-clear sweep. Used as the generic buffer/scratch store beneath FIFOs and packet buffers.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
ADDR_WIDTH, 4, address width.
DEPTH, 10, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
RW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data).

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  synchronous active-high reset.
EN_WR  in  1  write request.
ADDR_WR  in  ADDR_WIDTH  write address.
BE_WR  in  NUM_LANES  lane write enables; lane k covers D_IN[k*LANE_WIDTH +: LANE_WIDTH].
D_IN  in  DATA_WIDTH  write data.
EN_RD  in  1  read request.
ADDR_RD  in  ADDR_WIDTH  read address.
D_OUT  out  DATA_WIDTH  read data, registered.
VALID_RD  out  1  one-cycle strobe: D_OUT carries the result of a read.
BUSY  out  1  high during reset and clear sweep; requests ignored.
ERR_ADDR  out  1  one-cycle strobe: an accepted request used address >= DEPTH.

Behaviour:
- Reset (RST=1 at an edge): D_OUT=0, VALID_RD=0, ERR_ADDR=0, BUSY=1, pipeline stages and valid bits cleared, FSM -> CLEAR, clear counter = 0. Memory contents are not cleared during RST itself.
- FSM states: CLEAR, READY.
- CLEAR: each cycle with RST=0 writes all-zero to mem[counter], then increments the counter. After writing DEPTH-1, FSM -> READY. BUSY falls at that same edge, so BUSY is high for exactly DEPTH cycles after RST is released. RST asserted mid-sweep restarts from address 0.
- READY: BUSY=0; requests accepted. READY -> CLEAR only via RST.
- EN_WR/EN_RD while BUSY=1: ignored; no memory change, no VALID_RD, no ERR_ADDR.
- Write: when EN_WR=1 and ADDR_WR < DEPTH, lanes with BE_WR[k]=1 are updated at the edge; other lanes keep their contents. BE_WR=0 leaves memory unchanged, with no error.
- Read: when EN_RD=1 and ADDR_RD < DEPTH, the word is sampled at the edge.
  - RD_LATENCY=1: D_OUT and VALID_RD are updated at that same edge (visible in the following cycle).
  - RD_LATENCY=2: one extra register stage is added after that edge.
- Back-to-back reads every cycle give full throughput.
- D_OUT holds its last value when no read completes; VALID_RD=0 in those cycles.
- Out of range (address >= DEPTH): the write is dropped. The read produces D_OUT=0 with VALID_RD=1 at normal latency. ERR_ADDR pulses one cycle after the request edge (pulses once even if both ports are out of range).
- Collision (EN_WR and EN_RD, same in-range address, same edge):
  - RW_MODE=0: read returns pre-write word.
  - RW_MODE=1: read returns merged word; enabled lanes come from D_IN, other lanes from old contents.
- Reset mid-read: in-flight pipeline results are discarded; VALID_RD stays 0.

Test Plan:
- Reset/clear: DEPTH=10, pulse RST 2 cycles -> BUSY=1 for exactly 10 cycles after release. Read all addresses 0..9 -> D_OUT=0, VALID_RD=1 each. EN_WR to addr 3 during BUSY has no effect.
- Write/read sweep: write D_IN=8'hA0+i to addr i for i=0..9 (BE=1), then read 9 down to 0 back-to-back -> D_OUT=8'hA9..8'hA0 in consecutive cycles. Run with RD_LATENCY=1 and 2 and check latency is exactly 1 or 2.
- Lane enables (DATA_WIDTH=16): write 16'h1234 to addr 5, then 16'hABCD with BE=2'b01 -> read addr 5 returns 16'h12CD.
- Collision: addr 2 holds 8'h11; same edge write 8'h22 and read addr 2 -> RW_MODE=0 returns 8'h11, RW_MODE=1 returns 8'h22. Next read returns 8'h22 in both modes.
- Out of range: DEPTH=10, ADDR_WIDTH=4. Write addr 12 -> ERR_ADDR one cycle, memory unchanged. Read addr 15 -> D_OUT=0, VALID_RD=1, ERR_ADDR=1.
- Reset mid-operation: RST during 2-stage read in flight and at clear counter=4 -> no VALID_RD. Clear restarts at 0 and BUSY is high 10 cycles after release.
